// File: rtl/mux_scan_seq.sv
// mux_scan_seq
//   Upstream sequencer for an 8:1 bit mux. On a start request it latches a
//   channel mask and a dwell value. It then steps the mux select through the
//   enabled channels in ascending order. Each channel is held for dwell+1
//   cycles, and the mux output is sampled on the last of those cycles. The
//   samples are collected into an 8-bit frame, and the frame is offered
//   downstream with a valid/ready handshake.
//
// Ports
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous reset, active-high
//   start        in   1        scan request, honoured only when idle
//   chan_mask    in   8        channels to scan, latched on start
//   dwell        in   DWELL_W  extra settle cycles per channel, latched on start
//   sel          out  3        mux select
//   mux_out      in   1        mux output
//   frame        out  8        collected samples (0 for masked channels)
//   frame_valid  out  1        frame complete, held until accepted
//   frame_ready  in   1        downstream accepts the frame
//   busy         out  1        scan in progress or frame awaiting acceptance
module mux_scan_seq #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         chan_mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         sel,
  input  logic               mux_out,
  output logic [7:0]         frame,
  output logic               frame_valid,
  input  logic               frame_ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [2:0]         sel_r, sel_s;
  logic [7:0]         frame_r, frame_s;
  logic               frame_valid_r, frame_valid_s;
  logic               busy_r, busy_s;
  logic [DWELL_W-1:0] count_r, count_s;
  logic [DWELL_W-1:0] dwell_r, dwell_s;
  logic [7:0]         mask_r, mask_s;
  logic [3:0]         next_s;

  // Lowest set bit of a non-zero mask.
  function automatic logic [2:0] lowest_chan(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      r = m[i] ? 3'(i) : r;
    end
    return r;
  endfunction

  // {found, index} of the lowest set mask bit strictly above cur.
  // Searching only upward means a scan never wraps back to a lower channel.
  function automatic logic [3:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      r = (m[i] && (i > int'(cur))) ? {1'b1, 3'(i)} : r;
    end
    return r;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_s  = state_r;
    sel_s    = sel_r;
    frame_s  = frame_r;
    count_s  = count_r;
    dwell_s  = dwell_r;
    mask_s   = mask_r;
    next_s   = next_chan(mask_r, sel_r);

    case (state_r)
      ST_IDLE: begin
        sel_s = 3'd0;
        if (start) begin
          mask_s  = chan_mask;
          dwell_s = dwell;
          frame_s = 8'd0;
          if (chan_mask != 8'd0) begin
            sel_s   = lowest_chan(chan_mask);
            count_s = dwell;
            state_s = ST_SCAN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (count_r != {DWELL_W{1'b0}}) begin
          count_s = count_r - {{(DWELL_W-1){1'b0}}, 1'b1};
        end else begin
          frame_s[sel_r] = mux_out;
          if (next_s[3]) begin
            sel_s   = next_s[2:0];
            count_s = dwell_r;
          end else begin
            state_s = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // Start is deliberately not looked at here, so a start that arrives
        // together with ready is dropped rather than queued.
        if (frame_ready) begin
          state_s = ST_IDLE;
          sel_s   = 3'd0;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        sel_s   = 3'd0;
      end
    endcase

    // Flags are derived from the next state so that they stay registered.
    frame_valid_s = (state_s == ST_DONE);
    busy_s        = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      sel_r         <= 3'd0;
      frame_r       <= 8'd0;
      frame_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      count_r       <= {DWELL_W{1'b0}};
      dwell_r       <= {DWELL_W{1'b0}};
      mask_r        <= 8'd0;
    end else begin
      state_r       <= state_s;
      sel_r         <= sel_s;
      frame_r       <= frame_s;
      frame_valid_r <= frame_valid_s;
      busy_r        <= busy_s;
      count_r       <= count_s;
      dwell_r       <= dwell_s;
      mask_r        <= mask_s;
    end
  end

  assign sel         = sel_r;
  assign frame       = frame_r;
  assign frame_valid = frame_valid_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed testbench for mux_scan_seq. The stimulus process pushes the
// expected frame, together with the cycle on which frame_valid must rise,
// into a queue. A separate monitor process pops and compares that entry
// whenever frame_valid rises. Cycle-level expectations such as select
// stepping, reset values and hold behaviour are checked inline.
module tb_mux_scan_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] chan_mask;
  logic [3:0] dwell;
  logic [2:0] sel;
  logic       mux_out;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready;
  logic       busy;
  logic [7:0] mux_in;

  typedef struct {
    logic [7:0] frame;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   cyc_cnt;
  logic prev_valid;

  mux_scan_seq #(.DWELL_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .chan_mask   (chan_mask),
    .dwell       (dwell),
    .sel         (sel),
    .mux_out     (mux_out),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .busy        (busy)
  );

  // 8:1 mux model driven by the DUT select.
  assign mux_out = mux_in[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges so that frame latency can be checked.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // Scoreboard monitor: each rising edge of frame_valid consumes one entry.
  always @(negedge clk) begin
    if (!rst && frame_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_frame: got frame %0h with no scan pending", frame);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("frame", {24'd0, frame}, {24'd0, e.frame});
        chk("latency", cyc_cnt, e.cyc);
      end
    end
    prev_valid <= frame_valid;
  end

  // Call at a negedge: start is sampled on the following rising edge.
  // lat = number of cycles from that edge until frame_valid is set.
  task automatic issue(input logic [7:0] m, input logic [3:0] d, input logic [7:0] exp_frame,
                       input int lat);
    exp_t e;
    start     = 1'b1;
    chan_mask = m;
    dwell     = d;
    e.frame   = exp_frame;
    e.cyc     = cyc_cnt + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no frame_valid, expected one within 200 cycles", name);
    end
  endtask

  initial begin
    int ch_list[3];
    n_cmp       = 0;
    n_bad       = 0;
    cyc_cnt     = 0;
    prev_valid  = 1'b0;
    rst         = 1'b1;
    start       = 1'b0;
    chan_mask   = 8'd0;
    dwell       = 4'd0;
    frame_ready = 1'b0;
    mux_in      = 8'd0;

    // 1: reset with random inputs
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start       = 1'($urandom);
      chan_mask   = 8'($urandom);
      dwell       = 4'($urandom);
      frame_ready = 1'($urandom);
      mux_in      = 8'($urandom);
    end
    @(negedge clk);
    chk("rst_sel", {29'd0, sel}, 32'd0);
    chk("rst_frame", {24'd0, frame}, 32'd0);
    chk("rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst         = 1'b0;
    start       = 1'b0;
    frame_ready = 1'b1;
    @(negedge clk);
    chk("idle_sel", {29'd0, sel}, 32'd0);

    // 2: all channels, no dwell
    mux_in = 8'hA5;
    issue(8'hFF, 4'd0, 8'hA5, 8);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      chk("t2_sel", {29'd0, sel}, i);
      chk("t2_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("t2_valid", {31'd0, frame_valid}, 32'd1);
    chk("t2_sel_hold", {29'd0, sel}, 32'd7);
    @(negedge clk);
    chk("t2_valid_drop", {31'd0, frame_valid}, 32'd0);
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    chk("t2_idle_sel", {29'd0, sel}, 32'd0);

    // 3: sparse mask with dwell 3
    mux_in     = 8'hFF;
    ch_list[0] = 1;
    ch_list[1] = 4;
    ch_list[2] = 7;
    issue(8'b1001_0010, 4'd3, 8'h92, 12);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        start     = 1'b0;
        chan_mask = 8'h00;
        dwell     = 4'd0;
        chk("t3_sel", {29'd0, sel}, ch_list[c]);
      end
    end
    @(negedge clk);
    chk("t3_valid", {31'd0, frame_valid}, 32'd1);
    @(negedge clk);
    chk("t3_idle", {31'd0, busy}, 32'd0);

    // 4: downstream stall with start pulses, then start together with ready
    frame_ready = 1'b0;
    mux_in      = 8'h5A;
    issue(8'hFF, 4'd1, 8'h5A, 16);
    @(negedge clk);
    start = 1'b0;
    wait_valid("t4");
    for (int k = 0; k < 5; k++) begin
      start     = 1'b1;
      chan_mask = 8'h01;
      dwell     = 4'd0;
      @(negedge clk);
      chk("t4_hold_frame", {24'd0, frame}, 32'h5A);
      chk("t4_hold_valid", {31'd0, frame_valid}, 32'd1);
      chk("t4_hold_sel", {29'd0, sel}, 32'd7);
    end
    frame_ready = 1'b1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t4_valid_drop", {31'd0, frame_valid}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_frame_kept", {24'd0, frame}, 32'h5A);
    repeat (3) @(negedge clk);
    chk("t4_no_queue", {31'd0, busy}, 32'd0);

    // 5: empty mask completes immediately with a cleared frame
    issue(8'h00, 4'd5, 8'h00, 0);
    @(negedge clk);
    start = 1'b0;
    chk("t5_valid", {31'd0, frame_valid}, 32'd1);
    chk("t5_frame", {24'd0, frame}, 32'd0);
    chk("t5_sel", {29'd0, sel}, 32'd0);
    @(negedge clk);
    chk("t5_valid_drop", {31'd0, frame_valid}, 32'd0);

    // 6: reset in the middle of a scan, then a clean scan
    mux_in = 8'hFF;
    start  = 1'b1;
    chan_mask = 8'hFF;
    dwell  = 4'd0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (sel == 3'd3) break;
    end
    chk("t6_reached_sel3", {29'd0, sel}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_sel", {29'd0, sel}, 32'd0);
    chk("t6_rst_frame", {24'd0, frame}, 32'd0);
    chk("t6_rst_valid", {31'd0, frame_valid}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    mux_in = 8'h3C;
    issue(8'hFF, 4'd0, 8'h3C, 8);
    @(negedge clk);
    start = 1'b0;
    wait_valid("t6");
    repeat (2) @(negedge clk);
    chk("t6_idle", {31'd0, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
